uart_cmd_ctrl: RTL and testbench

Command sequencer behind the UART receiver: consumes the received byte stream (8-bit data plus single-cycle valid), parses one- and two-byte commands, and drives a simple register-bus write strobe or read request/acknowledge. Read results are returned as one byte through a valid/ready handshake to the UART transmit path. Handles inter-byte timeout on partial commands, read-acknowledge timeout, and bytes arriving while busy (overrun).

---
 rtl/uart_cmd_ctrl_if.sv | 42 ++++
 rtl/uart_cmd_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl_if
// Purpose  : Bundles every non-clock/reset signal of uart_cmd_ctrl:
//            - received byte stream  (rx_data_i, rx_valid_i)
//            - register write bus    (wr_addr_o, wr_data_o, wr_strobe_o)
//            - register read bus     (rd_addr_o, rd_req_o, rd_ack_i, rd_data_i)
//            - response byte stream  (tx_data_o, tx_valid_o, tx_ready_i)
//            - status                (timeout_o, overrun_o)
//            The master modport is the command controller; the slave modport
//            is its surroundings (UART receiver/transmitter and register file).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_cmd_ctrl_if;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [6:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic       wr_strobe_o;
  logic [6:0] rd_addr_o;
  logic       rd_req_o;
  logic       rd_ack_i;
  logic [7:0] rd_data_i;
  logic [7:0] tx_data_o;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic       timeout_o;
  logic       overrun_o;

  modport master (
    input  rx_data_i, rx_valid_i, rd_ack_i, rd_data_i, tx_ready_i,
    output wr_addr_o, wr_data_o, wr_strobe_o, rd_addr_o, rd_req_o,
           tx_data_o, tx_valid_o, timeout_o, overrun_o
  );

  modport slave (
    output rx_data_i, rx_valid_i, rd_ack_i, rd_data_i, tx_ready_i,
    input  wr_addr_o, wr_data_o, wr_strobe_o, rd_addr_o, rd_req_o,
           tx_data_o, tx_valid_o, timeout_o, overrun_o
  );
endinterface
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_ctrl
// Purpose  : Command sequencer behind a UART receiver. Parses one-byte read
//            commands (bit7=0) and two-byte write commands (bit7=1, then a
//            data byte), drives a register write strobe or a read
//            request/acknowledge, and returns read data as one byte through a
//            valid/ready handshake. Aborts partial writes and unanswered reads
//            after TIMEOUT_CLOCKS cycles and flags bytes dropped while busy.
// Ports    : clock  - system clock, rising edge
//            reset  - synchronous, active-high
//            bus    - uart_cmd_ctrl_if.master (rx stream, write bus, read
//                     bus, tx stream, timeout/overrun status)
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CLOCKS = 4096
) (
  input  logic             clock,
  input  logic             reset,
  uart_cmd_ctrl_if.master  bus
);

  localparam int             TW        = $clog2(TIMEOUT_CLOCKS);
  localparam logic [TW-1:0]  TMR_LOAD  = TW'(TIMEOUT_CLOCKS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_READ = 2'd2,
    S_SEND = 2'd3
  } state_t;

  state_t        state_q,     state_d;
  logic [TW-1:0] timer_q,     timer_d;
  logic [6:0]    cmd_addr_q,  cmd_addr_d;
  logic [6:0]    wr_addr_q,   wr_addr_d;
  logic [7:0]    wr_data_q,   wr_data_d;
  logic          wr_strobe_q, wr_strobe_d;
  logic [6:0]    rd_addr_q,   rd_addr_d;
  logic          rd_req_q,    rd_req_d;
  logic [7:0]    tx_data_q,   tx_data_d;
  logic          tx_valid_q,  tx_valid_d;
  logic          timeout_q,   timeout_d;
  logic          overrun_q,   overrun_d;

  logic          timer_zero;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      cmd_addr_q  <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_strobe_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_req_q    <= 1'b0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      cmd_addr_q  <= cmd_addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_strobe_q <= wr_strobe_d;
      rd_addr_q   <= rd_addr_d;
      rd_req_q    <= rd_req_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      timeout_q   <= timeout_d;
      overrun_q   <= overrun_d;
    end
  end

  assign timer_zero = (timer_q == '0);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    cmd_addr_d  = cmd_addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strobe_d = 1'b0;
    rd_addr_d   = rd_addr_q;
    rd_req_d    = rd_req_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    timeout_d   = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (bus.rx_valid_i) begin
          timer_d = TMR_LOAD;
          if (bus.rx_data_i[7]) begin
            // Write address is held privately so the visible write bus only
            // changes when a complete command has arrived.
            cmd_addr_d = bus.rx_data_i[6:0];
            state_d    = S_DATA;
          end else begin
            rd_addr_d = bus.rx_data_i[6:0];
            rd_req_d  = 1'b1;
            state_d   = S_READ;
          end
        end
      end

      S_DATA: begin
        // The data byte wins over expiry on the timer-zero cycle.
        if (bus.rx_valid_i) begin
          wr_addr_d   = cmd_addr_q;
          wr_data_d   = bus.rx_data_i;
          wr_strobe_d = 1'b1;
          state_d     = S_IDLE;
        end else if (timer_zero) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_READ: begin
        if (bus.rx_valid_i) begin
          overrun_d = 1'b1;
        end
        // The acknowledge wins over expiry on the timer-zero cycle.
        if (bus.rd_ack_i) begin
          tx_data_d  = bus.rd_data_i;
          rd_req_d   = 1'b0;
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else if (timer_zero) begin
          rd_req_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      S_SEND: begin
        if (bus.rx_valid_i) begin
          overrun_d = 1'b1;
        end
        if (bus.tx_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.wr_strobe_o = wr_strobe_q;
  assign bus.rd_addr_o   = rd_addr_q;
  assign bus.rd_req_o    = rd_req_q;
  assign bus.tx_data_o   = tx_data_q;
  assign bus.tx_valid_o  = tx_valid_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_ctrl
// Purpose  : Self-checking bench for uart_cmd_ctrl. Commands are issued as
//            transactions (write with a chosen inter-byte gap, read with a
//            chosen acknowledge delay and ready delay); expected outputs for
//            every cycle follow from the command timing rules: entry one
//            cycle after the command byte, events accepted up to TIMEOUT
//            cycles after the command byte, timeout pulse one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

  localparam int T = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;

  uart_cmd_ctrl_if bus ();

  uart_cmd_ctrl #(.TIMEOUT_CLOCKS(T)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [6:0] exp_wa   = '0;
  logic [7:0] exp_wd   = '0;
  logic       exp_ovr  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs set after tick() are sampled at the next rising edge; outputs read
  // after tick() are the values registered at the edge just passed.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_common(input string tag, input logic exp_stb, input logic exp_to);
    check({tag, "_strobe"},  {31'd0, bus.wr_strobe_o}, {31'd0, exp_stb});
    check({tag, "_timeout"}, {31'd0, bus.timeout_o},   {31'd0, exp_to});
    check({tag, "_overrun"}, {31'd0, bus.overrun_o},   {31'd0, exp_ovr});
    check({tag, "_wr_addr"}, {25'd0, bus.wr_addr_o},   {25'd0, exp_wa});
    check({tag, "_wr_data"}, {24'd0, bus.wr_data_o},   {24'd0, exp_wd});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wr_addr"}, {25'd0, bus.wr_addr_o},   32'd0);
    check({tag, "_wr_data"}, {24'd0, bus.wr_data_o},   32'd0);
    check({tag, "_strobe"},  {31'd0, bus.wr_strobe_o}, 32'd0);
    check({tag, "_rd_addr"}, {25'd0, bus.rd_addr_o},   32'd0);
    check({tag, "_rd_req"},  {31'd0, bus.rd_req_o},    32'd0);
    check({tag, "_tx_data"}, {24'd0, bus.tx_data_o},   32'd0);
    check({tag, "_tx_valid"},{31'd0, bus.tx_valid_o},  32'd0);
    check({tag, "_timeout"}, {31'd0, bus.timeout_o},   32'd0);
    check({tag, "_overrun"}, {31'd0, bus.overrun_o},   32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data_i  = b;
    bus.rx_valid_i = 1'b1;
    tick();
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'($urandom);
  endtask

  // Write command; the data byte follows 'gap' cycles after the command byte.
  // gap > T means the data byte never comes and the command must time out.
  task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int gap);
    send_byte({1'b1, a});
    if (gap <= T) begin
      for (int k = 1; k < gap; k++) begin
        check_common("wr_wait", 1'b0, 1'b0);
        tick();
      end
      check_common("wr_wait", 1'b0, 1'b0);
      send_byte(d);
      exp_wa = a;
      exp_wd = d;
      check_common("wr_done", 1'b1, 1'b0);
      check("wr_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
    end else begin
      for (int k = 1; k <= T; k++) begin
        check_common("wr_part", 1'b0, 1'b0);
        tick();
      end
      check_common("wr_abort", 1'b0, 1'b1);
    end
  endtask

  // Read command; acknowledge 'ack_dly' cycles after the command byte
  // (ack_dly > T means no acknowledge in time), then tx_ready low for
  // 'rdy_dly' cycles. Optional dropped bytes in READ/SEND and a reset
  // applied while the response is pending.
  task automatic do_read(input logic [6:0] a, input int ack_dly, input logic [7:0] d,
                         input int rdy_dly, input bit drop_rd, input bit drop_send,
                         input bit rst_in_send);
    int wait_n;
    send_byte({1'b0, a});
    wait_n = (ack_dly <= T) ? ack_dly : T + 1;
    for (int k = 1; k < wait_n; k++) begin
      check_common("rd_wait", 1'b0, 1'b0);
      check("rd_req",      {31'd0, bus.rd_req_o},   32'd1);
      check("rd_addr",     {25'd0, bus.rd_addr_o},  {25'd0, a});
      check("rd_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
      bus.tx_ready_i = 1'($urandom);
      if (drop_rd && k == 1) begin
        send_byte(8'h44);
        exp_ovr = 1'b1;
      end else begin
        tick();
      end
      bus.tx_ready_i = 1'b0;
    end
    if (ack_dly <= T) begin
      check("rd_req_last", {31'd0, bus.rd_req_o}, 32'd1);
      bus.rd_ack_i  = 1'b1;
      bus.rd_data_i = d;
      tick();
      bus.rd_ack_i  = 1'b0;
      bus.rd_data_i = 8'($urandom);
      check_common("rd_ack", 1'b0, 1'b0);
      check("rd_req_drop", {31'd0, bus.rd_req_o},   32'd0);
      check("tx_valid",    {31'd0, bus.tx_valid_o}, 32'd1);
      check("tx_data",     {24'd0, bus.tx_data_o},  {24'd0, d});
      for (int r = 0; r < rdy_dly; r++) begin
        // A stray acknowledge while sending must not disturb the response.
        bus.rd_ack_i  = (r == 0);
        bus.rd_data_i = ~d;
        if (drop_send && r == 0) begin
          send_byte(8'h99);
          exp_ovr = 1'b1;
        end else begin
          tick();
        end
        bus.rd_ack_i = 1'b0;
        check_common("tx_hold", 1'b0, 1'b0);
        check("tx_hold_valid", {31'd0, bus.tx_valid_o}, 32'd1);
        check("tx_hold_data",  {24'd0, bus.tx_data_o},  {24'd0, d});
      end
      if (rst_in_send) begin
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        exp_ovr = 1'b0;
        exp_wa  = '0;
        exp_wd  = '0;
        check_all_zero("rst_send");
      end else begin
        bus.tx_ready_i = 1'b1;
        tick();
        bus.tx_ready_i = 1'b0;
        check_common("tx_done", 1'b0, 1'b0);
        check("tx_done_valid", {31'd0, bus.tx_valid_o}, 32'd0);
      end
    end else begin
      check_common("rd_abort", 1'b0, 1'b1);
      check("rd_abort_req", {31'd0, bus.rd_req_o}, 32'd0);
      bus.rd_ack_i  = 1'b1;
      bus.rd_data_i = d;
      tick();
      bus.rd_ack_i = 1'b0;
      check_common("late_ack", 1'b0, 1'b0);
      check("late_ack_tx_valid", {31'd0, bus.tx_valid_o}, 32'd0);
      check("late_ack_req",      {31'd0, bus.rd_req_o},   32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.rx_data_i  = '0;
    bus.rx_valid_i = 1'b0;
    bus.rd_ack_i   = 1'b0;
    bus.rd_data_i  = '0;
    bus.tx_ready_i = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_all_zero("reset");

    do_write(7'h05, 8'h3C, 1);
    do_read(7'h12, 3, 8'hA7, 5, 1'b0, 1'b0, 1'b0);
    do_write(7'h01, 8'h00, T + 1);
    do_write(7'h02, 8'h55, 1);
    do_read(7'h07, T + 1, 8'h66, 0, 1'b0, 1'b0, 1'b0);
    do_read(7'h30, 4, 8'hB1, 1, 1'b1, 1'b0, 1'b0);
    do_write(7'h7F, 8'hC3, T);
    do_read(7'h0F, T, 8'h3E, 0, 1'b0, 1'b0, 1'b0);
    do_read(7'h21, 2, 8'h5A, 3, 1'b0, 1'b1, 1'b1);
    do_write(7'h11, 8'h22, 2);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(7'($urandom), 8'($urandom), int'($urandom_range(1, T + 2)));
      end else begin
        do_read(7'($urandom), int'($urandom_range(1, T + 2)), 8'($urandom),
                int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0), 1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
